// File: rtl/ctrl_pkg.sv
// Shared control-word encodings and datapath state for the sequencing controller/datapath pair.
package ctrl_pkg;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_LOAD = 3'b001;
  localparam logic [2:0] S_ADD  = 3'b011;
  localparam logic [2:0] S_FIN  = 3'b101;

  typedef enum logic {IDLE, MUL} dp_state_e;

  typedef struct packed {
    logic       e;
    logic       m;
    logic [2:0] s;
    logic       done;
  } ctrl_word_t;

endpackage

// File: rtl/shift_add_mul.sv
// WIDTH-cycle unsigned shift-add multiplier; done pulses in the cycle the product is complete.
module shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  // The first partial product is folded into the start edge so the result is
  // complete after WIDTH-1 further edges, letting done land in cycle WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand   <= {{WIDTH{1'b0}}, a} << 1;
      mplier  <= b >> 1;
      cnt     <= CW'(WIDTH - 1);
      run     <= (WIDTH > 1);
      done    <= (WIDTH == 1);
    end else if (run) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_datapath.sv
// Executes the controller's control word: load, add, finalize (sum or multiply), valid/ready result.
// Define CTRL_DATAPATH_MUL_EN to build the multiplier; otherwise m=1 finalizes as a sum.
module ctrl_datapath
  import ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               e,
  input  logic               m,
  input  logic               s2,
  input  logic               s1,
  input  logic               s0,
  input  logic               done,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               cmd_err,
  output logic               overrun
);

  ctrl_word_t         cw;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, ld_val;
  logic               accept, fin, sum_fin, mul_done, ld_en, bad;

  assign cw     = {e, m, s2, s1, s0, done};
  assign accept = cw.e && !busy;
  assign fin    = accept && (cw.s == S_FIN) && cw.done;
  assign bad    = cw.e && (busy || !((cw.s == S_LOAD) || (cw.s == S_ADD) ||
                                     ((cw.s == S_FIN) && cw.done)));

`ifdef CTRL_DATAPATH_MUL_EN
  dp_state_e          state;
  logic               mul_start;
  logic [2*WIDTH-1:0] prod;

  assign mul_start = fin && cw.m;
  assign sum_fin   = fin && !cw.m;
  assign ld_val    = mul_done ? prod : acc_q;

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .done    (mul_done),
    .product (prod)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mul_start) begin state <= MUL;  busy <= 1'b1; end
        MUL:  if (mul_done)  begin state <= IDLE; busy <= 1'b0; end
        default: begin state <= IDLE; busy <= 1'b0; end
      endcase
    end
  end
`else
  assign sum_fin  = fin;
  assign mul_done = 1'b0;
  assign ld_val   = acc_q;
  assign busy     = 1'b0;
`endif

  assign ld_en = sum_fin || mul_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      cmd_err      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (accept) begin
        case (cw.s)
          S_LOAD: begin a_q <= a_in; b_q <= b_in; acc_q <= '0; end
          S_ADD:  acc_q <= {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
          default: ;
        endcase
      end
      if (bad) cmd_err <= 1'b1;
      // A new result only displaces the old one if the consumer takes it this cycle.
      if (ld_en) begin
        if (!result_valid || result_ready) begin
          result       <= ld_val;
          result_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_datapath.sv
// Directed bench for ctrl_datapath (WIDTH=4); expectations follow CTRL_DATAPATH_MUL_EN if defined.
module tb_ctrl_datapath;
  import ctrl_pkg::*;

  logic       clk, reset_n, e, m, s2, s1, s0, done, result_ready;
  logic [3:0] a_in, b_in;
  logic [7:0] result;
  logic       result_valid, busy, cmd_err, overrun;
  int         checks, errors;

  ctrl_datapath #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .e(e), .m(m), .s2(s2), .s1(s1), .s0(s0),
    .done(done), .a_in(a_in), .b_in(b_in), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy),
    .cmd_err(cmd_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cw(input logic ee, input logic mm, input logic [2:0] ss, input logic dd,
                    input logic [3:0] aa, input logic [3:0] bb);
    e = ee; m = mm; {s2, s1, s0} = ss; done = dd; a_in = aa; b_in = bb;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cw(1'b0, 1'b0, S_IDLE, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; e = 0; m = 0; {s2, s1, s0} = 3'b000; done = 0;
    a_in = 0; b_in = 0; result_ready = 0;
    #2;
    chk("reset_valid", result_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_busy", busy, 0);
    chk("reset_flags", {cmd_err, overrun}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 3+5 sum with ready high: valid for exactly one cycle
    result_ready = 1;
    cw(1, 0, S_LOAD, 0, 4'd3, 4'd5);
    chk("sum_load_valid", result_valid, 0);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    chk("sum_add_valid", result_valid, 0);
    cw(1, 0, S_FIN, 1, 4'd0, 4'd0);
    chk("sum_fin_valid", result_valid, 1);
    chk("sum_fin_result", result, 8);
    idle();
    chk("sum_drain_valid", result_valid, 0);
    chk("sum_drain_result", result, 8);
    chk("sum_flags", {cmd_err, overrun}, 0);

    // load and consume in the same cycle: no overrun
    result_ready = 0;
    cw(1, 0, S_LOAD, 0, 4'd1, 4'd1);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    cw(1, 0, S_FIN, 1, 4'd0, 4'd0);
    chk("swap_first", result, 2);
    cw(1, 0, S_LOAD, 0, 4'd4, 4'd5);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    chk("swap_hold", {result_valid, result}, {1'b1, 8'd2});
    result_ready = 1;
    cw(1, 0, S_FIN, 1, 4'd0, 4'd0);
    chk("swap_new", {result_valid, result}, {1'b1, 8'd9});
    chk("swap_no_ovr", overrun, 0);
    idle();
    chk("swap_drain", result_valid, 0);

    // 15*15 finalize with m=1
    result_ready = 0;
    cw(1, 0, S_LOAD, 0, 4'd15, 4'd15);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    cw(1, 1, S_FIN, 1, 4'd0, 4'd0);
`ifdef CTRL_DATAPATH_MUL_EN
    chk("mul_busy1", {busy, result_valid}, 2'b10);
    for (int i = 2; i <= 4; i++) begin
      idle();
      chk($sformatf("mul_busy%0d", i), {busy, result_valid}, 2'b10);
    end
    idle();
    chk("mul_done", {busy, result_valid}, 2'b01);
    chk("mul_result", result, 225);
`else
    chk("mfin_busy", busy, 0);
    chk("mfin_valid", result_valid, 1);
    chk("mfin_result", result, 30);
`endif
    result_ready = 1;
    idle();
    chk("mul_drain", result_valid, 0);

`ifdef CTRL_DATAPATH_MUL_EN
    // control word during busy is dropped
    cw(1, 0, S_LOAD, 0, 4'd6, 4'd7);
    cw(1, 1, S_FIN, 1, 4'd0, 4'd0);
    chk("drop_err_pre", cmd_err, 0);
    cw(1, 0, S_LOAD, 0, 4'd1, 4'd1);
    chk("drop_err", cmd_err, 1);
    chk("drop_busy", busy, 1);
    idle(); idle(); idle();
    chk("drop_product", {result_valid, result}, {1'b1, 8'd42});
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    cw(1, 0, S_FIN, 1, 4'd0, 4'd0);
    chk("drop_ab_kept", result, 13);
    idle();
`endif

    do_reset();

    // illegal / unqualified words
    result_ready = 1;
    cw(1, 0, S_LOAD, 0, 4'd1, 4'd2);
    chk("ill_pre", cmd_err, 0);
    cw(1, 0, 3'b010, 0, 4'd9, 4'd9);
    chk("ill_err", cmd_err, 1);
    cw(1, 0, S_FIN, 0, 4'd9, 4'd9);
    chk("fin_nodone_valid", result_valid, 0);
    cw(0, 0, S_LOAD, 1, 4'd9, 4'd9);
    cw(0, 0, S_FIN, 1, 4'd9, 4'd9);
    chk("e0_ignored", result_valid, 0);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    cw(1, 0, S_FIN, 1, 4'd0, 4'd0);
    chk("ill_no_change", result, 3);
    chk("ill_sticky", cmd_err, 1);
    idle();

    do_reset();

    // overrun: two sums, no drain
    result_ready = 0;
    cw(1, 0, S_LOAD, 0, 4'd2, 4'd2);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    cw(1, 0, S_FIN, 1, 4'd0, 4'd0);
    chk("ovr_first", {result_valid, result}, {1'b1, 8'd4});
    cw(1, 0, S_LOAD, 0, 4'd7, 4'd9);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    cw(1, 0, S_FIN, 1, 4'd0, 4'd0);
    chk("ovr_held", {result_valid, result}, {1'b1, 8'd4});
    chk("ovr_flag", overrun, 1);
    result_ready = 1;
    idle();
    chk("ovr_drain", {result_valid, result}, {1'b0, 8'd4});
    chk("ovr_sticky", overrun, 1);

    // reset in the middle of a multiply
    result_ready = 0;
    cw(1, 0, S_LOAD, 0, 4'd15, 4'd15);
    cw(1, 0, S_ADD, 0, 4'd0, 4'd0);
    cw(1, 1, S_FIN, 1, 4'd0, 4'd0);
    idle();
`ifdef CTRL_DATAPATH_MUL_EN
    chk("mid_busy", busy, 1);
`endif
    do_reset();
    repeat (6) idle();
    chk("mid_no_late", {busy, result_valid, result}, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
